// File: rtl/sid_pkg.sv
// sid_pkg: shared types and constants for the SID voice amplifier slice.
//   dca_state_t  : control states of the voice DCA (IDLE, MUL, HOLD)
//   WAVE_MID     : oscillator code that represents a zero-level sample
//   trunc_shift(): number of product LSBs dropped to form the output
package sid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } dca_state_t;

  localparam logic [11:0] WAVE_MID = 12'h800;

  // Dropping the low (prod_w - out_w) bits of a two's-complement product is
  // an arithmetic shift right, so the result floors toward minus infinity.
  function automatic int trunc_shift(input int prod_w, input int out_w);
    return prod_w - out_w;
  endfunction

endpackage

// File: rtl/sid_serial_mul.sv
// sid_serial_mul: signed-by-unsigned shift-add multiplier, one partial
// product per step.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : load operands, clear accumulator and iteration counter
//   step        : perform one iteration (add if multiplier LSB set, shift)
//   mcand_in    : signed two's-complement multiplicand (WAVE_W bits)
//   mplier_in   : unsigned multiplier (ENV_W bits)
//   done        : the iteration performed by the current step is the last
//   result      : top OUT_W bits of the sum this step produces; valid to
//                 capture on the cycle done is high
module sid_serial_mul
  import sid_pkg::*;
#(
  parameter int WAVE_W = 12,
  parameter int ENV_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [WAVE_W-1:0] mcand_in,
  input  logic [ENV_W-1:0]  mplier_in,
  output logic              done,
  output logic [OUT_W-1:0]  result
);

  localparam int P     = WAVE_W + ENV_W;
  localparam int SHIFT = trunc_shift(P, OUT_W);
  localparam int CNT_W = $clog2(ENV_W);

  logic [P-1:0]     acc_q;
  logic [P-1:0]     mcand_q;
  logic [P-1:0]     sum_next;
  logic [ENV_W-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;

  // The multiplicand is sign-extended to the full product width, so plain
  // modulo-2^P addition yields the exact signed product.
  assign sum_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign done     = (cnt_q == CNT_W'(ENV_W - 1));
  assign result   = sum_next[SHIFT +: OUT_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  // The operand registers are reset as well so a reset mid-multiply leaves
  // no stale partial product behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{ENV_W{mcand_in[WAVE_W-1]}}, mcand_in};
      mplier_q <= mplier_in;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= sum_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sid_voice_dca.sv
// sid_voice_dca: voice digitally controlled amplifier. Scales one unsigned
// oscillator sample by the envelope volume with a serial multiplier and
// hands the signed result to the mixer over valid/ready.
//   clk, reset          : clock, asynchronous active-high reset
//   clk_en              : voice clock enable; all state advances only when high
//   wave                : unsigned oscillator sample, WAVE_MID is zero level
//   vol                 : unsigned envelope volume
//   in_valid / in_ready : input handshake (ready only in IDLE)
//   out                 : signed scaled sample, top OUT_W bits of the product
//   out_valid/out_ready : output handshake; out holds after the handshake
module sid_voice_dca
  import sid_pkg::*;
#(
  parameter int WAVE_W = 12,
  parameter int ENV_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [WAVE_W-1:0] wave,
  input  logic [ENV_W-1:0]  vol,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  input  logic              out_ready
);

  dca_state_t        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_q;
  logic              mul_start, mul_step, mul_done, load_out;
  logic [OUT_W-1:0]  mul_result;
  logic [WAVE_W-1:0] wave_signed;

  // Removing the mid-scale offset turns the unsigned code into a
  // two's-complement sample in -2^(WAVE_W-1) .. 2^(WAVE_W-1)-1.
  assign wave_signed = wave - WAVE_W'(WAVE_MID);

  sid_serial_mul #(
    .WAVE_W (WAVE_W),
    .ENV_W  (ENV_W),
    .OUT_W  (OUT_W)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .step      (mul_step),
    .mcand_in  (wave_signed),
    .mplier_in (vol),
    .done      (mul_done),
    .result    (mul_result)
  );

  // start/step go straight to the datapath, so they are qualified with
  // clk_en here; everything else is only registered on enabled cycles.
  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    mul_start   = 1'b0;
    mul_step    = 1'b0;
    load_out    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready    = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid) begin
          mul_start = clk_en;
          state_d   = MUL;
        end
      end
      MUL: begin
        mul_step = clk_en;
        if (mul_done) begin
          load_out    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      if (load_out) begin
        out_q <= mul_result;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sid_voice_dca.sv
// tb_sid_voice_dca: directed self-checking bench for sid_voice_dca.
// Inputs are driven just after the falling edge and outputs are sampled at
// the falling edge, away from the active rising edge.
module tb_sid_voice_dca;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [11:0] wave;
  logic [7:0]  vol;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sid_voice_dca #(
    .WAVE_W (12),
    .ENV_W  (8),
    .OUT_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .wave      (wave),
    .vol       (vol),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete operation with out_ready held high: capture, fixed 8-cycle
  // latency, result, then the handshake back to IDLE.
  task automatic run_op(input string tag, input logic [11:0] w, input logic [7:0] v,
                        input logic [15:0] exp);
    int n = 0;
    clk_en    = 1'b1;
    out_ready = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    wave     = w;
    vol      = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wave     = 12'($urandom);
    vol      = 8'($urandom);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    repeat (7) @(negedge clk);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out"}, 32'(out), 32'(exp));
    @(negedge clk);
    check({tag, "_done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] en_pat;
    int          en_cnt;

    reset     = 1'b1;
    clk_en    = 1'b1;
    wave      = '0;
    vol       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 2047*255 = 521985 = 0x7F701 -> 0x7F70
    run_op("fs_pos", 12'hFFF, 8'hFF, 16'h7F70);
    // -2048*255 = -522240 = 0x80800 (20b) -> 0x8080
    run_op("fs_neg", 12'h000, 8'hFF, 16'h8080);
    run_op("mid", 12'h800, 8'hA5, 16'h0000);
    run_op("fs_pos2", 12'hFFF, 8'hFF, 16'h7F70);
    run_op("silence", 12'h123, 8'h00, 16'h0000);
    // -1*1 = -1 floors to -1
    run_op("round", 12'h7FF, 8'h01, 16'hFFFF);

    // Backpressure: result held while out_ready=0 and in_valid stays high.
    out_ready = 1'b0;
    wave      = 12'hFFF;
    vol       = 8'hFF;
    in_valid  = 1'b1;
    @(negedge clk);
    wave = 12'h000;
    vol  = 8'h02;
    repeat (7) @(negedge clk);
    check("bp_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_out", 32'(out), 32'h7F70);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out", 32'(out), 32'h7F70);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_out_kept", 32'(out), 32'h7F70);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_capture", 32'(in_ready), 32'd0);
    repeat (7) @(negedge clk);
    check("bp2_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    // -2048*2 = -4096 = 0xFF000 (20b) -> 0xFF00
    check("bp2_valid", 32'(out_valid), 32'd1);
    check("bp2_out", 32'(out), 32'hFF00);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp2_done", 32'(out_valid), 32'd0);

    // Clock-enable gating: 8 enabled edges spread over 12 cycles.
    // 0x9AB -> 427; 427*55 = 23485 = 0x05BBD -> 0x05BB
    out_ready = 1'b0;
    wave      = 12'h9AB;
    vol       = 8'h37;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    en_pat   = 12'b1101_1101_1001;
    en_cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      clk_en = en_pat[i];
      if (en_pat[i]) en_cnt++;
      @(negedge clk);
      check("gate_valid", 32'(out_valid), (en_cnt >= 8) ? 32'd1 : 32'd0);
    end
    check("gate_out", 32'(out), 32'h05BB);
    clk_en    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("gate_hold_valid", 32'(out_valid), 32'd1);
    clk_en = 1'b1;
    @(negedge clk);
    check("gate_handshake", 32'(out_valid), 32'd0);
    check("gate_out_kept", 32'(out), 32'h05BB);

    // Reset after 3 iterations aborts the multiply.
    out_ready = 1'b0;
    wave      = 12'hFFF;
    vol       = 8'hFF;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("abort_hold_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_pulse", 32'(out_valid), 32'd0);
    // 0xC00 -> 1024; 1024*128 = 131072 = 0x20000 -> 0x2000
    run_op("post_reset", 12'hC00, 8'h80, 16'h2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
